// File: rtl/discriminator_seq.sv
// Q8.8 GAN discriminator: 9 pixels -> 3 hard-tanh hidden units -> 1 hard-sigmoid score,
// time-multiplexed over one saturating MAC with valid/ready on both sides.
module discriminator_seq #(
    parameter int                 N_IN   = 9,
    parameter int                 N_HID  = 3,
    parameter int                 FRAC   = 8,
    parameter logic signed [15:0] THRESH = 16'sd128
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          valid_in,
    output logic                          in_ready,
    input  logic [16*N_IN-1:0]            pix_flat,
    input  logic [16*N_HID*(N_IN+1)-1:0]  flat_weights_L1,
    input  logic [16*(N_HID+1)-1:0]       flat_weights_L2,
    output logic                          valid_out,
    input  logic                          out_ready,
    output logic signed [15:0]            score,
    output logic                          real_flag
);

    localparam int N_W1   = N_HID * (N_IN + 1);
    localparam int N_W2   = N_HID + 1;
    localparam int K_AW   = (N_IN > 1) ? $clog2(N_IN + 1) : 1;
    localparam int J_AW   = (N_HID > 1) ? $clog2(N_HID + 1) : 1;
    localparam int W1_AW  = $clog2(N_W1);
    localparam int W2_AW  = $clog2(N_W2);
    localparam int H_AW   = (N_HID > 1) ? $clog2(N_HID) : 1;
    localparam logic signed [15:0] ONE  = 16'sd1 <<< FRAC;
    localparam logic signed [15:0] HALF = 16'sd1 <<< (FRAC - 1);

    typedef enum logic [2:0] {IDLE, L1_MAC, L1_ACT, L2_MAC, L2_ACT, DONE} state_t;

    state_t state_q, state_d;

    logic signed [15:0] pix_q [N_IN];
    logic signed [15:0] pix_d [N_IN];
    logic signed [15:0] w1_q  [N_W1];
    logic signed [15:0] w1_d  [N_W1];
    logic signed [15:0] w2_q  [N_W2];
    logic signed [15:0] w2_d  [N_W2];
    logic signed [15:0] h_q   [N_HID];
    logic signed [15:0] h_d   [N_HID];
    logic signed [31:0] acc_q, acc_d;
    logic [K_AW-1:0]    k_q, k_d;
    logic [J_AW-1:0]    j_q, j_d;
    logic signed [15:0] score_q, score_d;
    logic               real_q, real_d;
    logic               valid_q, valid_d;

    logic accept, mac_en, in_l2, act_l1, act_l2, out_clr;

    // Accumulator never wraps: sums clip at the 32-bit signed limits.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b);
        logic signed [32:0] s;
        s = {a[31], a} + {b[31], b};
        if (s[32] != s[31]) return s[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
        return s[31:0];
    endfunction

    function automatic logic signed [15:0] sat16(input logic signed [31:0] x);
        if (x > 32'sd32767)  return 16'sh7FFF;
        if (x < -32'sd32768) return 16'sh8000;
        return x[15:0];
    endfunction

    function automatic logic signed [15:0] hardtanh(input logic signed [15:0] x);
        if (x > ONE)  return ONE;
        if (x < -ONE) return -ONE;
        return x;
    endfunction

    function automatic logic signed [15:0] hsig(input logic signed [15:0] x);
        logic signed [15:0] t;
        t = (x >>> 2) + HALF;
        if (t < 16'sd0) return 16'sd0;
        if (t > ONE)    return ONE;
        return t;
    endfunction

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (accept) state_d = L1_MAC;
            L1_MAC: if (k_q == K_AW'(N_IN - 1)) state_d = L1_ACT;
            L1_ACT: state_d = (j_q == J_AW'(N_HID - 1)) ? L2_MAC : L1_MAC;
            L2_MAC: if (k_q == K_AW'(N_HID - 1)) state_d = L2_ACT;
            L2_ACT: state_d = DONE;
            DONE:   if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs / datapath strobes ----------------
    always_comb begin
        in_ready = (state_q == IDLE) && !rst;
        accept   = valid_in && in_ready;
        mac_en   = (state_q == L1_MAC) || (state_q == L2_MAC);
        in_l2    = (state_q == L2_MAC);
        act_l1   = (state_q == L1_ACT);
        act_l2   = (state_q == L2_ACT);
        out_clr  = (state_q == DONE) && out_ready;
    end

    assign valid_out = valid_q;
    assign score     = score_q;
    assign real_flag = real_q;

    // ---------------- shared MAC operands ----------------
    logic [W1_AW-1:0]   w1_idx, b1_idx;
    logic signed [15:0] op_a, op_b, bias;
    logic signed [31:0] prod, bias_ext, biased;
    logic signed [15:0] act_res, sig_res;

    always_comb begin
        w1_idx   = W1_AW'(j_q) * W1_AW'(N_IN + 1) + W1_AW'(k_q);
        b1_idx   = W1_AW'(j_q) * W1_AW'(N_IN + 1) + W1_AW'(N_IN);
        op_a     = in_l2 ? h_q[H_AW'(k_q)]  : pix_q[k_q];
        op_b     = in_l2 ? w2_q[W2_AW'(k_q)] : w1_q[w1_idx];
        prod     = 32'(op_a) * 32'(op_b);
        bias     = act_l2 ? w2_q[N_HID] : w1_q[b1_idx];
        bias_ext = 32'(bias) <<< FRAC;
        biased   = sat_add(acc_q, bias_ext);
        act_res  = sat16(biased >>> FRAC);
        sig_res  = hsig(act_res);
    end

    // ---------------- datapath next state ----------------
    always_comb begin
        pix_d   = pix_q;
        w1_d    = w1_q;
        w2_d    = w2_q;
        h_d     = h_q;
        acc_d   = acc_q;
        k_d     = k_q;
        j_d     = j_q;
        score_d = score_q;
        real_d  = real_q;
        valid_d = valid_q;

        if (accept) begin
            for (int k = 0; k < N_IN; k++) pix_d[k] = pix_flat[16*k +: 16];
            for (int k = 0; k < N_W1; k++) w1_d[k]  = flat_weights_L1[16*k +: 16];
            for (int k = 0; k < N_W2; k++) w2_d[k]  = flat_weights_L2[16*k +: 16];
            acc_d = '0;
            k_d   = '0;
            j_d   = '0;
        end

        if (mac_en) begin
            acc_d = sat_add(acc_q, prod);
            k_d   = k_q + K_AW'(1);
        end

        if (act_l1) begin
            h_d[H_AW'(j_q)] = hardtanh(act_res);
            acc_d = '0;
            k_d   = '0;
            j_d   = j_q + J_AW'(1);
        end

        if (act_l2) begin
            score_d = sig_res;
            real_d  = (sig_res >= THRESH);
            valid_d = 1'b1;
            acc_d   = '0;
            k_d     = '0;
        end

        if (out_clr) valid_d = 1'b0;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_IN; k++)  pix_q[k] <= '0;
            for (int k = 0; k < N_W1; k++)  w1_q[k]  <= '0;
            for (int k = 0; k < N_W2; k++)  w2_q[k]  <= '0;
            for (int k = 0; k < N_HID; k++) h_q[k]   <= '0;
            acc_q   <= '0;
            k_q     <= '0;
            j_q     <= '0;
            score_q <= '0;
            real_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            pix_q   <= pix_d;
            w1_q    <= w1_d;
            w2_q    <= w2_d;
            h_q     <= h_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
            j_q     <= j_d;
            score_q <= score_d;
            real_q  <= real_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_discriminator_seq.sv
// Self-checking bench for discriminator_seq: directed corner frames, backpressure,
// back-to-back frames, random frames against an integer reference model, mid-frame reset.
module tb_discriminator_seq;

    localparam longint MIN32 = -64'sd2147483648;
    localparam longint MAX32 = 64'sd2147483647;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               valid_in = 1'b0;
    logic               out_ready = 1'b0;
    logic [143:0]       pix_flat = '0;
    logic [479:0]       w1 = '0;
    logic [63:0]        w2 = '0;
    logic               in_ready, valid_out, real_flag;
    logic signed [15:0] score;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    discriminator_seq dut (
        .clk             (clk),
        .rst             (rst),
        .valid_in        (valid_in),
        .in_ready        (in_ready),
        .pix_flat        (pix_flat),
        .flat_weights_L1 (w1),
        .flat_weights_L2 (w2),
        .valid_out       (valid_out),
        .out_ready       (out_ready),
        .score           (score),
        .real_flag       (real_flag)
    );

    // ---------------- reference model (plain integer arithmetic) ----------------
    function automatic longint clampl(longint x, longint lo, longint hi);
        return (x < lo) ? lo : ((x > hi) ? hi : x);
    endfunction

    function automatic int model_score(logic [143:0] p, logic [479:0] a, logic [63:0] b);
        longint acc, r;
        longint h [3];
        for (int j = 0; j < 3; j++) begin
            acc = 0;
            for (int k = 0; k < 9; k++)
                acc = clampl(acc + longint'($signed(p[16*k +: 16])) *
                                   longint'($signed(a[16*(j*10+k) +: 16])), MIN32, MAX32);
            acc  = clampl(acc + longint'($signed(a[16*(j*10+9) +: 16])) * 256, MIN32, MAX32);
            r    = clampl(acc >>> 8, -32768, 32767);
            h[j] = clampl(r, -256, 256);
        end
        acc = 0;
        for (int k = 0; k < 3; k++)
            acc = clampl(acc + h[k] * longint'($signed(b[16*k +: 16])), MIN32, MAX32);
        acc = clampl(acc + longint'($signed(b[48 +: 16])) * 256, MIN32, MAX32);
        r   = clampl(acc >>> 8, -32768, 32767);
        return int'(clampl((r >>> 2) + 128, 0, 256));
    endfunction

    // ---------------- stimulus helpers (no checking inside) ----------------
    task automatic scramble_inputs();
        for (int k = 0; k < 9; k++)  pix_flat[16*k +: 16] = 16'($urandom);
        for (int k = 0; k < 30; k++) w1[16*k +: 16] = 16'($urandom);
        for (int k = 0; k < 4; k++)  w2[16*k +: 16] = 16'($urandom);
    endtask

    task automatic start_frame(output bit ok);
        int w;
        w = 0;
        while (!in_ready && w < 100) begin
            @(posedge clk); #1; w++;
        end
        ok = in_ready;
        if (!ok) return;
        valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        scramble_inputs();
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!valid_out && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1;
        n_checks++;
        if (valid_out !== 1'b0 || score !== 16'sd0 || real_flag !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: valid_out=%b score=%0d real_flag=%b in_ready=%b, expected 0/0/0/0",
                     valid_out, score, real_flag, in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: in_ready=%b expected 1", in_ready);
        end
    endtask

    task automatic run_expect(input string name, input logic signed [15:0] exp_s);
        bit ok;
        int lat;
        logic exp_r;
        exp_r = (exp_s >= 16'sd128);
        start_frame(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_accept: in_ready never rose", name);
            return;
        end
        wait_valid(lat);
        n_checks++;
        if (lat !== 34) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d edges expected 34", name, lat);
        end
        n_checks++;
        if (score !== exp_s || real_flag !== exp_r) begin
            n_fail++;
            $display("FAIL %s_score: got %0d/%b expected %0d/%b", name, score, real_flag, exp_s, exp_r);
        end
        consume();
        n_checks++;
        if (valid_out !== 1'b0 || in_ready !== 1'b1 || score !== exp_s) begin
            n_fail++;
            $display("FAIL %s_handshake: valid_out=%b in_ready=%b score=%0d expected 0/1/%0d",
                     name, valid_out, in_ready, score, exp_s);
        end
    endtask

    task automatic test_directed();
        // case 1: all weights zero, random pixels
        w1 = '0; w2 = '0;
        for (int k = 0; k < 9; k++) pix_flat[16*k +: 16] = 16'($urandom);
        run_expect("zero_weights", 16'sd128);
        // case 2/3: only L2 bias
        w1 = '0; w2 = '0; w2[48 +: 16] = 16'h0400;
        run_expect("l2_bias_pos", 16'sd256);
        w1 = '0; w2 = '0; w2[48 +: 16] = 16'hFC00;
        run_expect("l2_bias_neg", 16'sd0);
        // case 4: hidden layer saturates at +1.0
        for (int k = 0; k < 9; k++) pix_flat[16*k +: 16] = 16'h0100;
        for (int j = 0; j < 3; j++)
            for (int k = 0; k < 10; k++) w1[16*(j*10+k) +: 16] = (k == 9) ? 16'h0000 : 16'h0100;
        w2 = '0;
        for (int k = 0; k < 3; k++) w2[16*k +: 16] = 16'h0080;
        run_expect("hidden_sat", 16'sd224);
    endtask

    task automatic test_backpressure();
        bit ok;
        int lat;
        logic signed [15:0] s0;
        int bad;
        scramble_inputs();
        start_frame(ok);
        wait_valid(lat);
        n_checks++;
        if (!ok || valid_out !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_setup: ok=%0d valid_out=%b expected 1/1", ok, valid_out);
        end
        s0 = score;
        for (int i = 0; i < 10; i++) begin
            valid_in = i[0];
            for (int k = 0; k < 9; k++) pix_flat[16*k +: 16] = 16'($urandom);
            @(posedge clk); #1;
            n_checks++;
            if (valid_out !== 1'b1 || score !== s0 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: valid_out=%b score=%0d in_ready=%b expected 1/%0d/0",
                         i, valid_out, score, in_ready, s0);
            end
        end
        valid_in = 1'b0;
        consume();
        n_checks++;
        if (valid_out !== 1'b0 || in_ready !== 1'b1 || score !== s0) begin
            n_fail++;
            $display("FAIL bp_release: valid_out=%b in_ready=%b score=%0d expected 0/1/%0d",
                     valid_out, in_ready, score, s0);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (valid_out !== 1'b0 || in_ready !== 1'b1) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL bp_no_ghost_frame: %0d busy cycles seen, expected 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int lat;
        logic [143:0] p;
        logic [479:0] a;
        logic [63:0]  b;
        logic signed [15:0] exp_s;
        scramble_inputs();
        start_frame(ok);
        wait_valid(lat);
        // second frame presented while the first score is being consumed
        scramble_inputs();
        p = pix_flat; a = w1; b = w2;
        exp_s = 16'(model_score(p, a, b));
        valid_in  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if (valid_out !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_no_accept_on_consume: valid_out=%b in_ready=%b expected 0/1",
                     valid_out, in_ready);
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
        scramble_inputs();
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_accept: in_ready=%b expected 0", in_ready);
        end
        wait_valid(lat);
        n_checks++;
        if (lat !== 34 || score !== exp_s) begin
            n_fail++;
            $display("FAIL b2b_second: latency=%0d score=%0d expected 34/%0d", lat, score, exp_s);
        end
        consume();
    endtask

    task automatic test_random();
        bit ok;
        int lat;
        logic [143:0] p;
        logic [479:0] a;
        logic [63:0]  b;
        logic signed [15:0] exp_s;
        logic exp_r;
        int dly;
        for (int n = 0; n < 12; n++) begin
            if (n % 3 == 0) begin
                scramble_inputs();
            end else begin
                for (int k = 0; k < 9; k++)  pix_flat[16*k +: 16] = 16'($signed($urandom_range(1024)) - 512);
                for (int k = 0; k < 30; k++) w1[16*k +: 16] = 16'($signed($urandom_range(512)) - 256);
                for (int k = 0; k < 4; k++)  w2[16*k +: 16] = 16'($signed($urandom_range(1024)) - 512);
            end
            p = pix_flat; a = w1; b = w2;
            exp_s = 16'(model_score(p, a, b));
            exp_r = (exp_s >= 16'sd128);
            start_frame(ok);
            wait_valid(lat);
            n_checks++;
            if (!ok || lat !== 34) begin
                n_fail++;
                $display("FAIL rand%0d_latency: ok=%0d got %0d expected 34", n, ok, lat);
            end
            n_checks++;
            if (score !== exp_s || real_flag !== exp_r) begin
                n_fail++;
                $display("FAIL rand%0d_score: got %0d/%b expected %0d/%b", n, score, real_flag, exp_s, exp_r);
            end
            dly = $urandom_range(3);
            for (int i = 0; i < dly; i++) begin
                @(posedge clk); #1;
            end
            consume();
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        scramble_inputs();
        start_frame(ok);
        repeat (12) @(posedge clk);
        #1;
        n_checks++;
        if (!ok || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_busy: ok=%0d in_ready=%b expected 1/0", ok, in_ready);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (valid_out !== 1'b0 || score !== 16'sd0 || real_flag !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: valid_out=%b score=%0d real_flag=%b in_ready=%b expected 0/0/0/0",
                     valid_out, score, real_flag, in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        w1 = '0; w2 = '0;
        for (int k = 0; k < 9; k++) pix_flat[16*k +: 16] = 16'($urandom);
        run_expect("after_rst", 16'sd128);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
